// File: rtl/usb_crc_pkg.sv
// usb_crc_pkg: USB token CRC5 constants and helpers shared by the CRC engine.
package usb_crc_pkg;

    localparam int              CRC5_WIDTH    = 5;
    localparam logic [4:0]      CRC5_POLY     = 5'b00101;
    localparam logic [4:0]      CRC5_SEED     = 5'b11111;
    localparam logic [4:0]      CRC5_RESIDUAL = 5'b01100;

    function automatic logic [CRC5_WIDTH-1:0] crc5_next(input logic [CRC5_WIDTH-1:0] crc, input logic b);
        return {crc[CRC5_WIDTH-2:0], 1'b0} ^ ((b ^ crc[CRC5_WIDTH-1]) ? CRC5_POLY : '0);
    endfunction

    // Wire-order CRC field: inverted and bit-reversed so bit0 goes out first.
    function automatic logic [CRC5_WIDTH-1:0] crc5_field(input logic [CRC5_WIDTH-1:0] crc);
        logic [CRC5_WIDTH-1:0] f;
        f = '0;
        for (int i = 0; i < CRC5_WIDTH; i++)
            f[i] = ~crc[CRC5_WIDTH-1-i];
        return f;
    endfunction

endpackage

// File: rtl/crc_check_5bit.sv
// crc_check_5bit: serial USB CRC5 generator/checker clocked by the bit-enable strobe.
module crc_check_5bit
    import usb_crc_pkg::*;
(
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  shift_enable,
    input  logic                  serial_in,
    input  logic                  eop,
    input  logic                  shift_stop,
    input  logic                  crc_rcv,
    input  logic                  sync_rst,
    output logic [CRC5_WIDTH-1:0] parallel_out
);

    logic [CRC5_WIDTH-1:0] crc_q;
    logic [CRC5_WIDTH-1:0] result_q;

    // A check-mode eop freezes the register for that cycle so the verdict sees the pre-shift value.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc_q    <= CRC5_SEED;
            result_q <= '0;
        end else if (sync_rst) begin
            crc_q    <= CRC5_SEED;
            result_q <= '0;
        end else if (eop && crc_rcv) begin
            result_q <= (crc_q == CRC5_RESIDUAL) ? '1 : '0;
        end else if (shift_enable && !shift_stop) begin
            crc_q <= crc5_next(crc_q, serial_in);
        end
    end

    always_comb parallel_out = crc_rcv ? result_q : crc5_field(crc_q);

endmodule

// File: tb/tb_crc_check_5bit.sv
// tb_crc_check_5bit: directed self-checking bench for the CRC5 engine.
module tb_crc_check_5bit;

    logic       clk = 1'b0;
    logic       n_rst, shift_enable, serial_in, eop, shift_stop, crc_rcv, sync_rst;
    logic [4:0] parallel_out;
    int         checks = 0;
    int         failures = 0;

    crc_check_5bit dut (
        .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
        .eop(eop), .shift_stop(shift_stop), .crc_rcv(crc_rcv), .sync_rst(sync_rst),
        .parallel_out(parallel_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic b);
        shift_enable = 1'b1;
        serial_in    = b;
        tick();
        shift_enable = 1'b0;
        serial_in    = 1'b0;
    endtask

    task automatic strobes(input logic [15:0] bits, input int n);
        logic [15:0] v;
        v = bits;
        for (int i = 0; i < n; i++) strobe(v[i]);
    endtask

    task automatic pulse_sync;
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
    endtask

    task automatic pulse_eop;
        eop = 1'b1;
        tick();
        eop = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; shift_enable = 1'b0; serial_in = 1'b0; eop = 1'b0;
        shift_stop = 1'b0; crc_rcv = 1'b0; sync_rst = 1'b0;
        #12 n_rst = 1'b1;
        tick();
        chk("reset_gen", parallel_out, 5'b00000);
        crc_rcv = 1'b1; #1;
        chk("reset_result", parallel_out, 5'b00000);
        crc_rcv = 1'b0; #1;

        strobes(16'h001f, 5);
        chk("gen_five_ones", parallel_out, 5'b11111);
        pulse_sync();
        chk("sync_reseed", parallel_out, 5'b00000);

        strobes(16'h0000, 11);
        chk("gen_setup_zero", parallel_out, 5'b00010);

        pulse_sync();
        strobes(16'h0000, 4);
        chk("gen_four_zeros", parallel_out, 5'b10011);
        shift_stop = 1'b1;
        strobes(16'h0007, 3);
        shift_stop = 1'b0;
        chk("stop_frozen", parallel_out, 5'b10011);
        strobes(16'h0000, 7);
        chk("stop_resume", parallel_out, 5'b00010);

        pulse_sync();
        eop = 1'b1;
        strobe(1'b1);
        eop = 1'b0;
        chk("gen_eop_shifts", parallel_out, 5'b10000);
        crc_rcv = 1'b1; #1;
        chk("gen_eop_no_verdict", parallel_out, 5'b00000);

        pulse_sync();
        strobes(16'h03ff, 10);
        pulse_eop();
        chk("check_pass", parallel_out, 5'b11111);
        crc_rcv = 1'b0; #1;
        chk("check_crc_residual", parallel_out, 5'b11001);
        crc_rcv = 1'b1; #1;
        chk("toggle_keeps_result", parallel_out, 5'b11111);

        eop = 1'b1;
        strobe(1'b1);
        eop = 1'b0;
        chk("eop_shift_verdict", parallel_out, 5'b11111);
        crc_rcv = 1'b0; #1;
        chk("eop_shift_no_shift", parallel_out, 5'b11001);
        crc_rcv = 1'b1; #1;

        strobe(1'b0);
        chk("result_holds", parallel_out, 5'b11111);
        pulse_eop();
        chk("reverdict_fail", parallel_out, 5'b00000);

        pulse_sync();
        strobes(16'h01ff, 10);
        pulse_eop();
        chk("check_flipped", parallel_out, 5'b00000);

        pulse_sync();
        strobes(16'h03ff, 10);
        pulse_eop();
        chk("check_pass_again", parallel_out, 5'b11111);
        pulse_sync();
        chk("sync_clears_result", parallel_out, 5'b00000);

        strobes(16'h03ff, 10);
        pulse_eop();
        shift_enable = 1'b1; serial_in = 1'b1;
        tick();
        #2 n_rst = 1'b0;
        #1 chk("async_reset_result", parallel_out, 5'b00000);
        crc_rcv = 1'b0;
        #1 chk("async_reset_crc", parallel_out, 5'b00000);
        shift_enable = 1'b0; serial_in = 1'b0;
        #1 n_rst = 1'b1;
        tick();
        chk("after_reset_hold", parallel_out, 5'b00000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
